// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and encodings for the decode-stage forwarding/hazard unit.
package forward_hazard_unit_pkg;

    localparam int NREAD_DEF = 2;
    localparam int NFWD_DEF  = 3;
    localparam int NREGS_DEF = 32;
    localparam int RW_DEF    = $clog2(NREGS_DEF);

    typedef logic [NREGS_DEF-1:0] regbits_t;
    typedef logic [RW_DEF-1:0]    regidx_t;

    // forward_sel encoding: FWD_RF selects the register file, FWD_STAGE_BASE+k selects stage k
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

endpackage

// File: rtl/forward_hazard_unit_scoreboard.sv
// Busy-register scoreboard for long-latency results; set wins over clear, x0 never busy.
module forward_hazard_unit_scoreboard #(
    parameter int NREGS = 32,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             set_en,
    input  logic [RW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [RW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_idx] <= 1'b0;
            end
            if (set_en && (set_idx != '0)) begin
                busy[set_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Decode-stage operand forwarding select, read/WAW hazard detection and stall counter.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int NREAD = NREAD_DEF,
    parameter int NFWD  = NFWD_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int CW    = 32,
    localparam int RW   = $clog2(NREGS),
    localparam int SW   = $clog2(NFWD + 1)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREAD-1:0]           id_ren,
    input  logic [NREAD-1:0][RW-1:0]   id_rsel,
    input  logic [NFWD-1:0][RW-1:0]    fwd_rd,
    input  logic [NFWD-1:0]            fwd_wen,
    input  logic [NFWD-1:0]            fwd_ready,
    input  logic                       lat_issue,
    input  logic [RW-1:0]              lat_rd,
    input  logic                       lat_done,
    input  logic [RW-1:0]              lat_done_rd,
    input  logic                       id_lat,
    input  logic [RW-1:0]              id_rd,
    output logic [NREAD-1:0][SW-1:0]   forward_sel,
    output logic                       stall,
    output logic [CW-1:0]              stall_count,
    output logic [NREGS-1:0]           busy
);

    logic [NREAD-1:0] hit;
    logic [NREAD-1:0] hit_ready;
    logic [NREAD-1:0] read_hazard;
    logic             waw_hazard;

    forward_hazard_unit_scoreboard #(
        .NREGS (NREGS),
        .RW    (RW)
    ) u_scoreboard (
        .CLK     (CLK),
        .nRST    (nRST),
        .set_en  (lat_issue),
        .set_idx (lat_rd),
        .clr_en  (lat_done),
        .clr_idx (lat_done_rd),
        .busy    (busy)
    );

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        forward_sel = '0;
        hit         = '0;
        hit_ready   = '0;
        read_hazard = '0;
        for (int p = 0; p < NREAD; p++) begin
            forward_sel[p] = SW'(FWD_RF);
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_wen[k] && (fwd_rd[k] == id_rsel[p]) && (id_rsel[p] != '0)) begin
                    forward_sel[p] = SW'(FWD_STAGE_BASE + k);
                    hit[p]         = 1'b1;
                    hit_ready[p]   = fwd_ready[k];
                end
            end
            read_hazard[p] = id_ren[p] &&
                             ((hit[p] && !hit_ready[p]) || (!hit[p] && busy[id_rsel[p]]));
        end
    end

    assign waw_hazard = id_lat && (id_rd != '0) && busy[id_rd];
    assign stall      = (|read_hazard) || waw_hazard;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: vector table for forwarding, sequences for scoreboard/stall.
module tb_forward_hazard_unit;
    import forward_hazard_unit_pkg::*;

    logic              CLK;
    logic              nRST;
    logic [1:0]        id_ren;
    logic [1:0][4:0]   id_rsel;
    logic [2:0][4:0]   fwd_rd;
    logic [2:0]        fwd_wen;
    logic [2:0]        fwd_ready;
    logic              lat_issue;
    logic [4:0]        lat_rd;
    logic              lat_done;
    logic [4:0]        lat_done_rd;
    logic              id_lat;
    logic [4:0]        id_rd;

    logic [1:0][1:0]   forward_sel;
    logic              stall;
    logic [31:0]       stall_count;
    regbits_t          busy;

    logic [1:0][1:0]   forward_sel4;
    logic              stall4;
    logic [3:0]        stall_count4;
    regbits_t          busy4;

    int passed = 0;
    int total  = 0;

    forward_hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .id_ren(id_ren), .id_rsel(id_rsel),
        .fwd_rd(fwd_rd), .fwd_wen(fwd_wen), .fwd_ready(fwd_ready),
        .lat_issue(lat_issue), .lat_rd(lat_rd), .lat_done(lat_done),
        .lat_done_rd(lat_done_rd), .id_lat(id_lat), .id_rd(id_rd),
        .forward_sel(forward_sel), .stall(stall), .stall_count(stall_count), .busy(busy)
    );

    forward_hazard_unit #(.CW(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .id_ren(id_ren), .id_rsel(id_rsel),
        .fwd_rd(fwd_rd), .fwd_wen(fwd_wen), .fwd_ready(fwd_ready),
        .lat_issue(lat_issue), .lat_rd(lat_rd), .lat_done(lat_done),
        .lat_done_rd(lat_done_rd), .id_lat(id_lat), .id_rd(id_rd),
        .forward_sel(forward_sel4), .stall(stall4), .stall_count(stall_count4), .busy(busy4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] ren;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [4:0] rd0;
        logic [4:0] rd1;
        logic [4:0] rd2;
        logic [2:0] wen;
        logic [2:0] rdy;
        logic       lat;
        logic [4:0] ird;
        logic [1:0] es0;
        logic [1:0] es1;
        logic       est;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        id_ren = '0; id_rsel = '0; fwd_rd = '0; fwd_wen = '0; fwd_ready = '0;
        lat_issue = 1'b0; lat_rd = '0; lat_done = 1'b0; lat_done_rd = '0;
        id_lat = 1'b0; id_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        //            ren    rs0 rs1 rd0 rd1 rd2 wen     rdy     lat  ird  s0 s1 stall
        vecs[0] = '{2'b01, 5, 0, 5, 0, 5, 3'b101, 3'b111, 1'b0, 0, 1, 0, 1'b0};
        vecs[1] = '{2'b11, 6, 8, 1, 2, 6, 3'b111, 3'b111, 1'b0, 0, 3, 0, 1'b0};
        vecs[2] = '{2'b10, 3, 3, 9, 3, 3, 3'b110, 3'b101, 1'b0, 0, 2, 2, 1'b1};
        vecs[3] = '{2'b00, 3, 3, 9, 3, 3, 3'b110, 3'b101, 1'b0, 0, 2, 2, 1'b0};
        vecs[4] = '{2'b11, 0, 0, 0, 0, 0, 3'b111, 3'b000, 1'b0, 0, 0, 0, 1'b0};
        vecs[5] = '{2'b11, 4, 4, 4, 4, 4, 3'b000, 3'b000, 1'b0, 0, 0, 0, 1'b0};
        vecs[6] = '{2'b01, 10, 11, 10, 11, 10, 3'b111, 3'b110, 1'b0, 0, 1, 2, 1'b1};
        vecs[7] = '{2'b10, 10, 11, 10, 11, 10, 3'b111, 3'b110, 1'b0, 0, 1, 2, 1'b0};
        vecs[8] = '{2'b00, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1'b1, 7, 0, 0, 1'b0};

        clear_inputs();
        nRST = 1'b0;
        #12;
        check("reset_busy", busy, 32'h0);
        check("reset_stall_count", stall_count, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        nRST = 1'b1;

        // Combinational forwarding/hazard vectors, scoreboard empty.
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            id_ren = vecs[i].ren;
            id_rsel[0] = vecs[i].rs0; id_rsel[1] = vecs[i].rs1;
            fwd_rd[0] = vecs[i].rd0; fwd_rd[1] = vecs[i].rd1; fwd_rd[2] = vecs[i].rd2;
            fwd_wen = vecs[i].wen; fwd_ready = vecs[i].rdy;
            id_lat = vecs[i].lat; id_rd = vecs[i].ird;
            #1;
            check($sformatf("vec%0d_sel0", i), {30'b0, forward_sel[0]}, {30'b0, vecs[i].es0});
            check($sformatf("vec%0d_sel1", i), {30'b0, forward_sel[1]}, {30'b0, vecs[i].es1});
            check($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].est});
        end

        // Load-use: stage 0 not ready, then ready.
        @(negedge CLK);
        clear_inputs();
        fwd_rd[0] = 7; fwd_wen = 3'b001; fwd_ready = 3'b000;
        id_ren = 2'b10; id_rsel[1] = 7;
        #1;
        check("loaduse_stall", {31'b0, stall}, 32'h1);
        @(negedge CLK);
        fwd_ready = 3'b001;
        #1;
        check("loaduse_ready_stall", {31'b0, stall}, 32'h0);
        check("loaduse_ready_sel1", {30'b0, forward_sel[1]}, 32'h1);

        // Long-latency op on x9, three stalled edges.
        clear_inputs();
        do_reset();
        @(negedge CLK);
        lat_issue = 1'b1; lat_rd = 9;
        @(negedge CLK);
        lat_issue = 1'b0;
        check("lat_busy9", busy, 32'h0000_0200);
        id_ren = 2'b01; id_rsel[0] = 9;
        #1;
        check("lat_stall", {31'b0, stall}, 32'h1);
        @(negedge CLK);
        @(negedge CLK);
        check("lat_stall_held", {31'b0, stall}, 32'h1);
        lat_done = 1'b1; lat_done_rd = 9;
        @(negedge CLK);
        lat_done = 1'b0;
        #1;
        check("lat_done_busy", busy, 32'h0);
        check("lat_done_stall", {31'b0, stall}, 32'h0);
        check("lat_stall_count", stall_count, 32'd3);

        // Set wins over clear; x0 never busy or forwarded.
        clear_inputs();
        do_reset();
        @(negedge CLK);
        lat_issue = 1'b1; lat_rd = 4; lat_done = 1'b1; lat_done_rd = 4;
        @(negedge CLK);
        lat_issue = 1'b1; lat_rd = 0; lat_done = 1'b0;
        check("setwins_busy4", busy, 32'h0000_0010);
        @(negedge CLK);
        lat_issue = 1'b0;
        check("x0_not_busy", busy, 32'h0000_0010);
        lat_done = 1'b1; lat_done_rd = 20;
        fwd_rd[0] = 0; fwd_wen = 3'b001; fwd_ready = 3'b000;
        id_ren = 2'b11; id_rsel[0] = 0; id_rsel[1] = 0;
        #1;
        check("x0_sel0", {30'b0, forward_sel[0]}, 32'h0);
        check("x0_sel1", {30'b0, forward_sel[1]}, 32'h0);
        check("x0_stall", {31'b0, stall}, 32'h0);
        @(negedge CLK);
        lat_done_rd = 4;
        check("done_nonbusy_ignored", busy, 32'h0000_0010);
        @(negedge CLK);
        lat_done = 1'b0;
        check("done_clears4", busy, 32'h0);

        // WAW stall then async reset mid-stall.
        clear_inputs();
        do_reset();
        @(negedge CLK);
        lat_issue = 1'b1; lat_rd = 12;
        @(negedge CLK);
        lat_issue = 1'b0;
        id_lat = 1'b1; id_rd = 12;
        #1;
        check("waw_stall", {31'b0, stall}, 32'h1);
        @(negedge CLK);
        @(negedge CLK);
        check("waw_stall_count", stall_count, 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_mid_busy", busy, 32'h0);
        check("rst_mid_count", stall_count, 32'h0);
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        lat_done = 1'b1; lat_done_rd = 12;
        @(negedge CLK);
        lat_done = 1'b0;
        check("stale_done_busy", busy, 32'h0);
        check("stale_done_stall", {31'b0, stall}, 32'h0);
        check("stale_done_count", stall_count, 32'h0);

        // Saturation with a 4-bit counter.
        clear_inputs();
        do_reset();
        @(negedge CLK);
        lat_issue = 1'b1; lat_rd = 12;
        @(negedge CLK);
        lat_issue = 1'b0;
        id_lat = 1'b1; id_rd = 12;
        for (int c = 0; c < 20; c++) @(negedge CLK);
        check("sat_count4", {28'b0, stall_count4}, 32'd15);
        check("sat_count32", stall_count, 32'd20);
        @(negedge CLK);
        check("sat_hold4", {28'b0, stall_count4}, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter NREAD, default 2, meaning decode read ports.
REQ-002 SHALL have parameter NFWD, default 3, meaning forwarding stages; index 0 is youngest.
REQ-003 SHALL have parameter NREGS, default 32, meaning architectural registers; RW = clog2(NREGS).
REQ-004 SHALL have parameter CW, default 32, meaning stall-counter width.
REQ-005 SHALL have port CLK  in  1  clock; single clock domain.
REQ-006 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-007 SHALL have port id_ren  in  NREAD  per-port read enable.
REQ-008 SHALL have port id_rsel  in  NREAD x RW  source register per port.
REQ-009 SHALL have port fwd_rd  in  NFWD x RW  destination register of each stage.
REQ-010 SHALL have port fwd_wen  in  NFWD  stage writes a register.
REQ-011 SHALL have port fwd_ready  in  NFWD  stage result available (0 for a load not yet returned).
REQ-012 SHALL have port lat_issue  in  1  long-latency op (mul/div) issued this cycle.
REQ-013 SHALL have port lat_rd  in  RW  destination of issued long-latency op.
REQ-014 SHALL have port lat_done  in  1  long-latency op writes back this cycle.
REQ-015 SHALL have port lat_done_rd  in  RW  destination of completing op.
REQ-016 SHALL have port id_lat  in  1  instruction in decode is long-latency.
REQ-017 SHALL have port id_rd  in  RW  destination of instruction in decode.
REQ-018 SHALL have port forward_sel  out  NREAD x clog2(NFWD+1)  0 = register file, k = stage k-1.
REQ-019 SHALL have port stall  out  1  hold decode this cycle.
REQ-020 SHALL have port stall_count  out  CW  saturating count of stalled cycles.
REQ-021 SHALL have port busy  out  NREGS  scoreboard state.

Function
REQ-022 For each port p, forward_sel[p] SHALL be k+1 for the lowest k with fwd_wen[k], fwd_rd[k]==id_rsel[p], id_rsel[p]!=0; otherwise 0.
REQ-023 forward_sel SHALL be combinational with zero latency; register 0 never forwards.
REQ-024 A read hazard SHALL exist when id_ren[p] is set and either the matched stage k has fwd_ready[k]=0, or busy[id_rsel[p]]=1 and no stage matches.
REQ-025 A WAW hazard SHALL exist when id_lat=1, id_rd!=0 and busy[id_rd]=1.
REQ-026 stall SHALL be the OR of all read and WAW hazards, combinationally.
REQ-027 On lat_issue with lat_rd!=0, busy[lat_rd] SHALL be set at the next CLK edge.
REQ-028 On lat_done, busy[lat_done_rd] SHALL clear at the next CLK edge.
REQ-029 Simultaneous lat_done and lat_issue to the same register SHALL leave busy set (set wins).
REQ-030 busy[0] SHALL remain 0.
REQ-031 lat_done on a non-busy register SHALL be ignored without error.
REQ-032 stall_count SHALL increment by 1 on each edge where stall=1, saturating at all-ones.
REQ-033 stall_count SHALL hold its value once saturated.

Reset
REQ-034 nRST low SHALL asynchronously clear busy and stall_count to 0.
REQ-035 Reset mid-operation SHALL discard pending scoreboard entries; a later lat_done for a discarded entry SHALL be ignored.
REQ-036 The combinational outputs SHALL reflect inputs and the cleared state during reset.

Structure
REQ-037 The shared types package SHALL hold regbits_t, the NREGS/NFWD defaults, and the forward_sel encoding constants FWD_RF=0 and FWD_STAGE_BASE=1.
REQ-038 One sub-module, scoreboard (busy vector with set/clear ports), SHALL be instantiated; the forward/priority logic SHALL remain in the top module.

Verification
REQ-039 Test 1: fwd_rd[0]=5 and fwd_rd[2]=5, both wen and ready, id_rsel[0]=5 -> forward_sel[0]=1, stall=0.
REQ-040 Test 2: fwd_rd[0]=7 with wen=1 and ready=0, id_ren[1]=1, id_rsel[1]=7 -> stall=1; next cycle ready=1 -> stall=0 and forward_sel[1]=1.
REQ-041 Test 3: lat_issue with lat_rd=9; next cycle a read of x9 -> stall=1 for 3 cycles; lat_done with lat_done_rd=9 -> busy[9]=0 and stall=0 after the edge; stall_count=3.
REQ-042 Test 4: lat_issue and lat_done both to x4 in one cycle -> busy[4]=1; lat_issue with lat_rd=0 -> busy[0]=0; reads of x0 -> forward_sel=0.
REQ-043 Test 5: busy[12]=1 with id_lat=1 and id_rd=12 -> stall=1; nRST pulse mid-stall -> busy=0 and stall_count=0 immediately.
REQ-044 Test 6: CW=4 held stalled for 20 cycles -> stall_count=15.
